fft_fp2int_dispatch: RTL and testbench

Parametrised round-robin dispatcher between the FFT datapath and N_CH replicated HLS float-to-int conversion cores (ap_ctrl_hs). It accepts one float word per valid/ready handshake and launches it on the next core in rotation. It collects each core's result and returns the results in original input order on a valid/ready output stream. Each core has at most one item in flight, so order is kept with two rotating pointers and no tag FIFO.

---
 rtl/fft_fp2int_dispatch.sv | 125 ++++++++++++
 tb/tb_fft_fp2int_dispatch.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_fp2int_dispatch.sv
// Round-robin dispatch of a float stream onto N_CH ap_ctrl_hs float-to-int cores; results return in input order.
// Latency: accept->ap_start 1 cycle, ap_done->out_valid 2 cycles at the head core; in_ready drops when the next core is busy or N_CH items are outstanding.
module fft_fp2int_dispatch #(
   parameter int N_CH   = 3,
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(N_CH + 1)
) (
   input  logic                     s_axi_aclk,
   input  logic                     s_axi_areset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   output logic [N_CH-1:0]          ap_start,
   input  logic [N_CH-1:0]          ap_ready,
   input  logic [N_CH-1:0]          ap_done,
   output logic [N_CH*DATA_W-1:0]   input_r,
   input  logic [N_CH*DATA_W-1:0]   output_r,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [CNT_W-1:0]         inflight,
   output logic                     protocol_err
);
   localparam int               PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_CH - 1);
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(N_CH);

   logic [N_CH-1:0]        r_busy;
   logic [N_CH-1:0]        r_start_pend;
   logic [N_CH-1:0]        r_hold_vld;
   logic [DATA_W-1:0]      r_hold_dat [N_CH];
   logic [N_CH*DATA_W-1:0] r_arg;
   logic [PTR_W-1:0]       r_disp_ptr;
   logic [PTR_W-1:0]       r_out_ptr;
   logic                   r_out_vld;
   logic [DATA_W-1:0]      r_out_dat;
   logic [CNT_W-1:0]       r_inflight;
   logic                   r_err;

   logic                   w_in_rdy;
   logic                   w_disp;
   logic                   w_load;
   logic                   w_out_hs;
   logic [N_CH-1:0]        w_capture;
   logic [N_CH-1:0]        w_bad_done;

   function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // A result parked in the output register no longer holds its core, so the
   // outstanding count is capped separately to keep inflight within N_CH.
   assign w_in_rdy   = ~r_busy[r_disp_ptr] & (r_inflight != FULL);
   assign w_disp     = in_valid & w_in_rdy;
   assign w_load     = r_hold_vld[r_out_ptr] & (~r_out_vld | out_ready);
   assign w_out_hs   = r_out_vld & out_ready;
   assign w_capture  = ap_done & r_busy & ~r_start_pend & ~r_hold_vld;
   assign w_bad_done = ap_done & ~w_capture;

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         r_busy       <= '0;
         r_start_pend <= '0;
         r_hold_vld   <= '0;
         r_arg        <= '0;
         r_disp_ptr   <= '0;
         r_out_ptr    <= '0;
         r_out_vld    <= 1'b0;
         r_out_dat    <= '0;
         r_inflight   <= '0;
         r_err        <= 1'b0;
         for (int c = 0; c < N_CH; c++) begin
            r_hold_dat[c] <= '0;
         end
      end else begin
         if (w_disp) begin
            r_disp_ptr <= f_next(r_disp_ptr);
         end

         if (w_load) begin
            r_out_dat <= r_hold_dat[r_out_ptr];
            r_out_vld <= 1'b1;
            r_out_ptr <= f_next(r_out_ptr);
         end else if (w_out_hs) begin
            r_out_vld <= 1'b0;
         end

         r_inflight <= r_inflight + CNT_W'(w_disp) - CNT_W'(w_out_hs);

         if (|w_bad_done) begin
            r_err <= 1'b1;
         end

         // Dispatch needs ~busy and load needs hold_vld (implies busy), so the
         // per-core updates below never collide on the same bit.
         for (int c = 0; c < N_CH; c++) begin
            if (w_disp && (r_disp_ptr == PTR_W'(c))) begin
               r_busy[c]                    <= 1'b1;
               r_start_pend[c]              <= 1'b1;
               r_arg[c*DATA_W +: DATA_W]    <= in_data;
            end
            if (r_start_pend[c] && ap_ready[c]) begin
               r_start_pend[c] <= 1'b0;
            end
            if (w_capture[c]) begin
               r_hold_vld[c] <= 1'b1;
               r_hold_dat[c] <= output_r[c*DATA_W +: DATA_W];
            end
            if (w_load && (r_out_ptr == PTR_W'(c))) begin
               r_hold_vld[c] <= 1'b0;
               r_busy[c]     <= 1'b0;
            end
         end
      end
   end

   assign in_ready     = w_in_rdy;
   assign ap_start     = r_start_pend;
   assign input_r      = r_arg;
   assign out_valid    = r_out_vld;
   assign out_data     = r_out_dat;
   assign inflight     = r_inflight;
   assign protocol_err = r_err;

endmodule

// File: tb/tb_fft_fp2int_dispatch.sv
// Bench for fft_fp2int_dispatch: behavioural cores, an in-order scoreboard and directed corner cases.
module tb_fft_fp2int_dispatch;

   typedef struct {
      logic [31:0] f;
      logic [31:0] res;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // N_CH = 3 instance
   logic         in_valid3 = 1'b0;
   logic         in_ready3;
   logic [31:0]  in_data3 = '0;
   logic [2:0]   ap_start3;
   logic [2:0]   ap_ready3 = '0;
   logic [2:0]   ap_done3 = '0;
   logic [95:0]  input_r3;
   logic [95:0]  output_r3 = '0;
   logic         out_valid3;
   logic         out_ready3 = 1'b0;
   logic [31:0]  out_data3;
   logic [1:0]   inflight3;
   logic         perr3;

   // N_CH = 5 instance
   logic         in_valid5 = 1'b0;
   logic         in_ready5;
   logic [31:0]  in_data5 = '0;
   logic [4:0]   ap_start5;
   logic [4:0]   ap_ready5 = '0;
   logic [4:0]   ap_done5 = '0;
   logic [159:0] input_r5;
   logic [159:0] output_r5 = '0;
   logic         out_valid5;
   logic         out_ready5 = 1'b0;
   logic [31:0]  out_data5;
   logic [2:0]   inflight5;
   logic         perr5;

   fft_fp2int_dispatch #(.N_CH(3), .DATA_W(32)) dut3 (
      .s_axi_aclk(clk), .s_axi_areset(rst),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
      .ap_start(ap_start3), .ap_ready(ap_ready3), .ap_done(ap_done3),
      .input_r(input_r3), .output_r(output_r3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
      .inflight(inflight3), .protocol_err(perr3)
   );

   fft_fp2int_dispatch #(.N_CH(5), .DATA_W(32)) dut5 (
      .s_axi_aclk(clk), .s_axi_areset(rst),
      .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
      .ap_start(ap_start5), .ap_ready(ap_ready5), .ap_done(ap_done5),
      .input_r(input_r5), .output_r(output_r5),
      .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
      .inflight(inflight5), .protocol_err(perr5)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Reference float-to-int: truncate toward zero.
   function automatic logic [31:0] conv(input logic [31:0] f);
      int          e;
      logic [31:0] m;
      logic [31:0] r;
      e = int'(f[30:23]) - 127;
      m = {8'd0, 1'b1, f[22:0]};
      if (e < 0)        r = '0;
      else if (e >= 23) r = m << (e - 23);
      else              r = m >> (23 - e);
      if (f[31]) r = -r;
      return r;
   endfunction

   function automatic logic [31:0] rand_float();
      logic [31:0] r;
      r[31]    = 1'($urandom_range(0, 1));
      r[30:23] = 8'($urandom_range(120, 156));
      r[22:0]  = 23'($urandom);
      return r;
   endfunction

   // Core-model controls, written only by the stimulus process.
   int       lat3 [3];
   logic [2:0] force_low3 = '0;
   bit       rand_mode = 1'b0;
   int       spur_req3 = 0;
   int       spur_core3 = 0;

   // Behavioural ap_ctrl_hs cores: accept on start&ready, pulse done after a latency.
   int          cnt3 [3];
   logic [31:0] arg3 [3];
   int          spur_ack3 = 0;
   int          cnt5 [5];
   logic [31:0] arg5 [5];
   always @(negedge clk) begin
      for (int c = 0; c < 3; c++) begin
         ap_done3[c] = 1'b0;
         if (rst) begin
            cnt3[c] = 0;
         end else begin
            if (cnt3[c] > 0) begin
               cnt3[c]--;
               if (cnt3[c] == 0) begin
                  ap_done3[c] = 1'b1;
                  output_r3[c*32 +: 32] = conv(arg3[c]);
               end
            end
            ap_ready3[c] = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (force_low3[c]) ap_ready3[c] = 1'b0;
            if (ap_start3[c] && ap_ready3[c]) begin
               arg3[c] = input_r3[c*32 +: 32];
               cnt3[c] = rand_mode ? int'($urandom_range(1, 8)) : lat3[c];
            end
         end
      end
      if (spur_req3 != spur_ack3) begin
         spur_ack3 = spur_req3;
         ap_done3[spur_core3] = 1'b1;
      end
      for (int c = 0; c < 5; c++) begin
         ap_done5[c] = 1'b0;
         if (rst) begin
            cnt5[c] = 0;
         end else begin
            if (cnt5[c] > 0) begin
               cnt5[c]--;
               if (cnt5[c] == 0) begin
                  ap_done5[c] = 1'b1;
                  output_r5[c*32 +: 32] = conv(arg5[c]);
               end
            end
            ap_ready5[c] = 1'b1;
            if (ap_start5[c]) begin
               arg5[c] = input_r5[c*32 +: 32];
               cnt5[c] = 1;
            end
         end
      end
   end

   // Scoreboard for the N_CH=3 instance: expected results in acceptance order.
   bit          mon_en = 1'b0;
   logic [31:0] sb [$];
   logic [31:0] got3 [$];
   int          model_inf = 0;
   always @(negedge clk) begin
      #1;
      if (mon_en) begin
         check("inflight_model", inflight3, model_inf);
         if (rst) begin
            sb.delete();
            got3.delete();
            model_inf = 0;
         end else begin
            if (out_valid3 && out_ready3) begin
               got3.push_back(out_data3);
               if (sb.size() == 0) begin
                  check("out_unexpected", out_data3, 32'hxxxx_xxxx);
               end else begin
                  check("out_order", out_data3, sb.pop_front());
               end
               model_inf--;
            end
            if (in_valid3 && in_ready3) begin
               sb.push_back(conv(in_data3));
               model_inf++;
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send3(input logic [31:0] d);
      bit hs;
      hs = 1'b0;
      in_valid3 = 1'b1;
      in_data3  = d;
      for (int k = 0; k < 200 && !hs; k++) begin
         @(negedge clk);
         hs = in_ready3;
         @(posedge clk);
         #1;
      end
      in_valid3 = 1'b0;
      check("send3_accepted", hs, 1'b1);
   endtask

   task automatic send5(input logic [31:0] d);
      bit hs;
      hs = 1'b0;
      in_valid5 = 1'b1;
      in_data5  = d;
      for (int k = 0; k < 200 && !hs; k++) begin
         @(negedge clk);
         hs = in_ready5;
         @(posedge clk);
         #1;
      end
      in_valid5 = 1'b0;
      check("send5_accepted", hs, 1'b1);
   endtask

   task automatic wait_idle3(input int maxc);
      int k;
      k = 0;
      while (inflight3 != 0 && k < maxc) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("drain_inflight", inflight3, 0);
   endtask

   vec_t tbl [11];
   int   acc;
   int   hi;
   bit   found;

   initial begin
      tbl[0]  = '{32'h3F80_0000, 32'd1};
      tbl[1]  = '{32'h4000_0000, 32'd2};
      tbl[2]  = '{32'h4040_0000, 32'd3};
      tbl[3]  = '{32'h4080_0000, 32'd4};
      tbl[4]  = '{32'h40A0_0000, 32'd5};
      tbl[5]  = '{32'h40C0_0000, 32'd6};
      tbl[6]  = '{32'h40E0_0000, 32'd7};
      tbl[7]  = '{32'h4100_0000, 32'd8};
      tbl[8]  = '{32'h3F00_0000, 32'd0};
      tbl[9]  = '{32'hC040_0000, 32'hFFFF_FFFD};
      tbl[10] = '{32'h447A_3000, 32'd1000};
      lat3[0] = 1; lat3[1] = 1; lat3[2] = 1;

      // Reset state
      do_reset();
      mon_en = 1'b1;
      check("rst_in_ready", in_ready3, 1'b1);
      check("rst_out_valid", out_valid3, 1'b0);
      check("rst_ap_start", ap_start3, 3'b000);
      check("rst_inflight", inflight3, 2'd0);
      check("rst_perr", perr3, 1'b0);
      check("rst_input_r", input_r3, 96'd0);
      check("rst_out_data", out_data3, 32'd0);

      // In-order reassembly with unequal core latencies
      lat3[0] = 7; lat3[1] = 2; lat3[2] = 1;
      out_ready3 = 1'b1;
      for (int i = 0; i < 11; i++) send3(tbl[i].f);
      wait_idle3(300);
      check("order_count", got3.size(), 11);
      for (int i = 0; i < 11; i++) begin
         if (i < got3.size()) check("order_vec", got3[i], tbl[i].res);
      end
      check("order_perr", perr3, 1'b0);

      // Backpressure: output stalled, three cores fill up
      do_reset();
      lat3[0] = 1; lat3[1] = 1; lat3[2] = 1;
      out_ready3 = 1'b0;
      acc = 0;
      in_valid3 = 1'b1;
      in_data3 = tbl[0].f;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (in_ready3) acc++;
         @(posedge clk);
         #1;
         if (acc < 4) in_data3 = tbl[acc].f;
      end
      check("bp_accepted", acc, 3);
      check("bp_in_ready", in_ready3, 1'b0);
      check("bp_inflight", inflight3, 2'd3);
      check("bp_out_valid", out_valid3, 1'b1);
      out_ready3 = 1'b1;
      @(posedge clk);
      #1;
      out_ready3 = 1'b0;
      check("bp_ready_after_hs", in_ready3, 1'b1);
      @(posedge clk);
      #1;
      in_valid3 = 1'b0;
      check("bp_4th_core0_start", ap_start3, 3'b001);
      check("bp_4th_core0_arg", input_r3[31:0], tbl[3].f);
      check("bp_4th_inflight", inflight3, 2'd3);
      out_ready3 = 1'b1;
      wait_idle3(100);
      check("bp_count", got3.size(), 4);

      // Stalled argument on core 1
      do_reset();
      lat3[0] = 3; lat3[1] = 3; lat3[2] = 3;
      force_low3 = 3'b010;
      send3(tbl[2].f);
      send3(tbl[4].f);
      hi = 0;
      for (int k = 0; k < 12; k++) begin
         if (ap_start3[1]) begin
            hi++;
            check("stall_arg_stable", input_r3[63:32], tbl[4].f);
            if (hi == 5) force_low3 = 3'b000;
         end
         @(posedge clk);
         #1;
      end
      check("stall_start_cycles", hi, 5);
      wait_idle3(100);
      check("stall_count", got3.size(), 2);
      if (got3.size() == 2) begin
         check("stall_first", got3[0], 32'd3);
         check("stall_second", got3[1], 32'd5);
      end

      // Spurious done on idle core 2
      spur_core3 = 2;
      spur_req3++;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("spur_perr", perr3, 1'b1);
      check("spur_out_valid", out_valid3, 1'b0);
      check("spur_inflight", inflight3, 2'd0);
      check("spur_in_ready", in_ready3, 1'b1);
      check("spur_ap_start", ap_start3, 3'b000);
      repeat (5) @(posedge clk);
      #1;
      check("spur_perr_sticky", perr3, 1'b1);

      // Randomised traffic against the scoreboard
      do_reset();
      check("rand_perr_cleared", perr3, 1'b0);
      rand_mode = 1'b1;
      for (int k = 0; k < 1500; k++) begin
         in_valid3  = ($urandom_range(0, 2) != 0);
         in_data3   = rand_float();
         out_ready3 = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      in_valid3  = 1'b0;
      out_ready3 = 1'b1;
      wait_idle3(400);
      rand_mode = 1'b0;
      check("rand_perr", perr3, 1'b0);
      check("rand_sb_empty", sb.size(), 0);

      // Mid-flight reset on a five-core instance
      out_ready5 = 1'b1;
      for (int i = 0; i < 7; i++) begin
         send5(tbl[i].f);
         if (i == 5) check("n5_wrap_to_core0", input_r5[31:0], tbl[5].f);
      end
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         if (inflight5 == 3'd2) begin
            found = 1'b1;
            out_ready5 = 1'b0;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      check("n5_two_outstanding", found, 1'b1);
      do_reset();
      check("n5_inflight", inflight5, 3'd0);
      check("n5_out_valid", out_valid5, 1'b0);
      check("n5_in_ready", in_ready5, 1'b1);
      check("n5_ap_start", ap_start5, 5'b00000);
      check("n5_input_r", input_r5, 160'd0);
      check("n5_perr", perr5, 1'b0);
      out_ready5 = 1'b1;
      send5(tbl[7].f);
      check("n5_next_core0_start", ap_start5, 5'b00001);
      check("n5_next_core0_arg", input_r5[31:0], tbl[7].f);
      repeat (10) @(posedge clk);
      #1;
      check("n5_idle_after", inflight5, 3'd0);
      check("n5_perr_end", perr5, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
